// File: rtl/in_arb_pkg.sv
// Shared state encoding, default widths and pointer helper for the input
// round-robin arbiter and its selector.
package in_arb_pkg;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_CTRL_WIDTH = DEF_DATA_WIDTH / 8;
   localparam int DEF_NUM_QUEUES = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } arb_state_e;

   // Next queue index after idx, wrapping at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/input_rr_arbiter_rr_select.sv
// rr_select: finds the first asserted request at or above ptr, wrapping
// around the request vector.
module rr_select
   import in_arb_pkg::*;
#(
   parameter int N = DEF_NUM_QUEUES,
   parameter int W = $clog2(DEF_NUM_QUEUES)
)(
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         valid
);

   logic [W-1:0] w_j;

   // Scan from farthest to nearest so the nearest hit is written last.
   always_comb begin
      idx   = ptr;
      valid = |req;
      w_j   = ptr;
      for (int k = N - 1; k >= 0; k--) begin
         w_j = W'((int'(ptr) + k) % N);
         idx = req[w_j] ? w_j : idx;
      end
   end

endmodule

// File: rtl/input_rr_arbiter.sv
// Round-robin packet arbiter over NUM_QUEUES FWFT input queues.
// Optional per-queue packet counters: define INPUT_RR_ARBITER_STATS_EN.
module input_rr_arbiter
   import in_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int NUM_QUEUES = DEF_NUM_QUEUES
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
   input  logic [NUM_QUEUES-1:0]            in_empty,
   output logic [NUM_QUEUES-1:0]            in_rd_en,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [CTRL_WIDTH-1:0]            out_ctrl,
   output logic                             out_wr,
   input  logic                             out_rdy,
   output logic                             state,
   output logic                             eop,
   output logic [$clog2(NUM_QUEUES)-1:0]    grant_q
`ifdef INPUT_RR_ARBITER_STATS_EN
   ,
   output logic [NUM_QUEUES*32-1:0]         pkt_cnt
`endif
);

   localparam int QW = $clog2(NUM_QUEUES);

   arb_state_e            r_state;
   arb_state_e            w_state_nxt;
   logic [QW-1:0]         r_grant_q;
   logic [QW-1:0]         r_rr_ptr;
   logic                  r_seen_body;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [CTRL_WIDTH-1:0] r_out_ctrl;
   logic                  r_out_wr;
   logic                  r_eop;

   logic [QW-1:0]         w_sel_idx;
   logic                  w_sel_valid;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic [CTRL_WIDTH-1:0] w_head_ctrl;
   logic                  w_head_empty;
   logic                  w_pop;
   logic                  w_end;
   logic                  w_grant_load;
   logic [NUM_QUEUES-1:0] w_rd_en;

   rr_select #(
      .N (NUM_QUEUES),
      .W (QW)
   ) u_rr_select (
      .req   (~in_empty),
      .ptr   (r_rr_ptr),
      .idx   (w_sel_idx),
      .valid (w_sel_valid)
   );

   assign w_head_data  = in_data[int'(r_grant_q)*DATA_WIDTH +: DATA_WIDTH];
   assign w_head_ctrl  = in_ctrl[int'(r_grant_q)*CTRL_WIDTH +: CTRL_WIDTH];
   assign w_head_empty = in_empty[r_grant_q];

   // Reset gates the pop so an abandoned packet keeps its words queued.
   assign w_pop        = (r_state == IN_PKT) && !w_head_empty && out_rdy && !reset;
   assign w_end        = w_pop && (w_head_ctrl != '0) && r_seen_body;
   assign w_grant_load = (r_state == IDLE) && w_sel_valid;

   // Pop strobe for the granted queue only.
   always_comb begin
      w_rd_en = '0;
      if (w_pop) begin
         w_rd_en[r_grant_q] = 1'b1;
      end else begin
         w_rd_en = '0;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_sel_valid) w_state_nxt = IN_PKT;
            else             w_state_nxt = IDLE;
         end
         IN_PKT: begin
            if (w_end) w_state_nxt = IDLE;
            else       w_state_nxt = IN_PKT;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Grant, round-robin pointer, header tracking and output word register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant_q   <= '0;
         r_rr_ptr    <= '0;
         r_seen_body <= 1'b0;
         r_out_data  <= '0;
         r_out_ctrl  <= '0;
         r_out_wr    <= 1'b0;
         r_eop       <= 1'b0;
      end else begin
         r_out_wr <= w_pop;
         r_eop    <= w_end;
         if (w_pop) begin
            r_out_data <= w_head_data;
            r_out_ctrl <= w_head_ctrl;
         end
         // Leading nonzero-ctrl words are header; the end needs a body word first.
         if (w_grant_load) begin
            r_grant_q   <= w_sel_idx;
            r_seen_body <= 1'b0;
         end else if (w_pop && (w_head_ctrl == '0)) begin
            r_seen_body <= 1'b1;
         end
         if (w_end) begin
            r_rr_ptr <= QW'(wrap_inc(int'(r_grant_q), NUM_QUEUES));
         end
      end
   end

   assign in_rd_en = w_rd_en;
   assign out_data = r_out_data;
   assign out_ctrl = r_out_ctrl;
   assign out_wr   = r_out_wr;
   assign eop      = r_eop;
   assign state    = r_state;
   assign grant_q  = r_grant_q;

`ifdef INPUT_RR_ARBITER_STATS_EN
   logic [31:0] r_pkt_cnt [NUM_QUEUES];

   // Per-queue forwarded-packet counters, stepping with each packet end.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int q = 0; q < NUM_QUEUES; q++) r_pkt_cnt[q] <= 32'd0;
      end else if (w_end) begin
         r_pkt_cnt[r_grant_q] <= r_pkt_cnt[r_grant_q] + 32'd1;
      end
   end

   for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
      assign pkt_cnt[g*32 +: 32] = r_pkt_cnt[g];
   end
`endif

endmodule

// File: tb/tb_input_rr_arbiter.sv
// Directed self-checking bench for input_rr_arbiter with FWFT queue models.
// Covers the INPUT_RR_ARBITER_STATS_EN counters when that macro is defined.
module tb_input_rr_arbiter;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int NQ = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [NQ*DW-1:0] in_data;
   logic [NQ*CW-1:0] in_ctrl;
   logic [NQ-1:0]    in_empty;
   logic [NQ-1:0]    in_rd_en;
   logic [DW-1:0]    out_data;
   logic [CW-1:0]    out_ctrl;
   logic             out_wr;
   logic             out_rdy;
   logic             state;
   logic             eop;
   logic [1:0]       grant_q;
`ifdef INPUT_RR_ARBITER_STATS_EN
   logic [NQ*32-1:0] pkt_cnt;
`endif

   input_rr_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
      .in_empty(in_empty), .in_rd_en(in_rd_en), .out_data(out_data),
      .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy), .state(state),
      .eop(eop), .grant_q(grant_q)
`ifdef INPUT_RR_ARBITER_STATS_EN
      , .pkt_cnt(pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   // FWFT queue models
   logic [CW+DW-1:0] mem [NQ][64];
   int hd [NQ] = '{default: 0};
   int tl [NQ] = '{default: 0};

   always_comb begin
      in_empty = '0;
      in_data  = '0;
      in_ctrl  = '0;
      for (int q = 0; q < NQ; q++) begin
         in_empty[q]        = (hd[q] == tl[q]);
         in_data[q*DW +: DW] = mem[q][hd[q]][DW-1:0];
         in_ctrl[q*CW +: CW] = mem[q][hd[q]][CW+DW-1:DW];
      end
   end

   int   cyc = 0;
   logic pop_seen = 1'b0;
   int   proto_err = 0, lat_err = 0, eop_err = 0;
   logic mon_en = 1'b0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      pop_seen <= |in_rd_en;
      if ($countones(in_rd_en) > 1) proto_err <= proto_err + 1;
      for (int q = 0; q < NQ; q++) begin
         if (in_rd_en[q]) begin
            if (hd[q] == tl[q]) proto_err <= proto_err + 1;
            else                hd[q] <= hd[q] + 1;
         end
      end
   end

   logic [DW-1:0] log_data [128];
   logic [CW-1:0] log_ctrl [128];
   logic          log_eop  [128];
   int            log_cyc  [128];
   int            log_n = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (out_wr) begin
            log_data[log_n] <= out_data;
            log_ctrl[log_n] <= out_ctrl;
            log_eop[log_n]  <= eop;
            log_cyc[log_n]  <= cyc;
            log_n           <= log_n + 1;
         end
         if (eop && !out_wr)    eop_err <= eop_err + 1;
         if (out_wr !== pop_seen) lat_err <= lat_err + 1;
      end
   end

   int n_pass = 0, n_total = 0;
   int b;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input int q, input logic [7:0] c, input logic [63:0] d);
      mem[q][tl[q]] = {c, d};
      tl[q]++;
   endtask

   task automatic push_pkt3(input int q, input logic [63:0] base);
      push(q, 8'hFF, base);
      push(q, 8'h00, base + 64'd1);
      push(q, 8'h10, base + 64'd2);
   endtask

   task automatic wait_log(input int target, input int budget, input string tag);
      int i = 0;
      while (log_n < target && i < budget) begin
         tick();
         i++;
      end
      chk(tag, 64'(log_n >= target), 64'd1);
   endtask

   task automatic chk_word(input string tag, input int idx, input logic [7:0] c,
                           input logic [63:0] d, input logic e);
      chk({tag, "_data"}, log_data[idx], d);
      chk({tag, "_ctrl"}, 64'(log_ctrl[idx]), 64'(c));
      chk({tag, "_eop"},  64'(log_eop[idx]), 64'(e));
   endtask

   initial begin
      logic [7:0] c3 [3];
      c3 = '{8'hFF, 8'h00, 8'h10};
      reset   = 1'b1;
      out_rdy = 1'b1;
      repeat (2) tick();

      // Reset values
      chk("rst_state",   64'(state),    64'd0);
      chk("rst_grant",   64'(grant_q),  64'd0);
      chk("rst_out_wr",  64'(out_wr),   64'd0);
      chk("rst_eop",     64'(eop),      64'd0);
      chk("rst_rd_en",   64'(in_rd_en), 64'd0);
      chk("rst_data",    out_data,      64'd0);
      chk("rst_ctrl",    64'(out_ctrl), 64'd0);
      chk("rst_rr_ptr",  64'(dut.r_rr_ptr), 64'd0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Single 3-word packet from Q1
      b = log_n;
      push_pkt3(1, 64'h100);
      wait_log(b + 3, 30, "q1_pkt_done");
      for (int i = 0; i < 3; i++) chk_word("q1_w", b + i, c3[i], 64'h100 + 64'(i), i == 2);
      tick();
      chk("q1_state",  64'(state),   64'd0);
      chk("q1_grant",  64'(grant_q), 64'd1);
      chk("q1_rr_ptr", 64'(dut.r_rr_ptr), 64'd2);

      // All queues empty: idle holds, pointer unchanged
      repeat (5) tick();
      chk("idle_state",  64'(state),  64'd0);
      chk("idle_rr_ptr", 64'(dut.r_rr_ptr), 64'd2);
      chk("idle_log",    64'(log_n),  64'(b + 3));

      // Four queues, round robin from pointer 0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      b = log_n;
      for (int q = 0; q < NQ; q++) push_pkt3(q, 64'h200 + 64'(q * 16));
      wait_log(b + 12, 80, "rr4_done");
      for (int p = 0; p < NQ; p++)
         for (int i = 0; i < 3; i++)
            chk_word("rr4_w", b + p*3 + i, c3[i], 64'h200 + 64'(p*16 + i), i == 2);
      tick();
      chk("rr4_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

      // Backpressure mid-packet on Q2
      b = log_n;
      for (int i = 0; i < 6; i++)
         push(2, (i == 0) ? 8'hFF : (i == 5) ? 8'h10 : 8'h00, 64'h300 + 64'(i));
      wait_log(b + 2, 30, "bp_start");
      out_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_wr", 64'(out_wr),   64'd0);
         chk("bp_rd_en",  64'(in_rd_en), 64'd0);
      end
      out_rdy = 1'b1;
      wait_log(b + 6, 30, "bp_done");
      repeat (3) tick();
      chk("bp_count", 64'(log_n), 64'(b + 6));
      for (int i = 0; i < 6; i++)
         chk_word("bp_w", b + i, (i == 0) ? 8'hFF : (i == 5) ? 8'h10 : 8'h00,
                  64'h300 + 64'(i), i == 5);

      // Q0 runs dry mid-packet while Q3 waits
      reset = 1'b1;
      tick();
      reset = 1'b0;
      b = log_n;
      push(0, 8'hFF, 64'h400);
      push(0, 8'h00, 64'h401);
      push_pkt3(3, 64'h430);
      wait_log(b + 2, 30, "dry_start");
      repeat (6) tick();
      chk("dry_state", 64'(state),    64'd1);
      chk("dry_grant", 64'(grant_q),  64'd0);
      chk("dry_count", 64'(log_n),    64'(b + 2));
      chk("dry_rd_en", 64'(in_rd_en), 64'd0);
      push(0, 8'h00, 64'h402);
      push(0, 8'h10, 64'h403);
      wait_log(b + 7, 40, "dry_done");
      for (int i = 0; i < 4; i++)
         chk_word("dry_q0", b + i, (i == 0) ? 8'hFF : (i == 3) ? 8'h10 : 8'h00,
                  64'h400 + 64'(i), i == 3);
      for (int i = 0; i < 3; i++) chk_word("dry_q3", b + 4 + i, c3[i], 64'h430 + 64'(i), i == 2);

      // Reset during word 2 of a Q1 packet
      b = log_n;
      push(1, 8'hFF, 64'h500);
      push(1, 8'h00, 64'h501);
      push(1, 8'h00, 64'h502);
      push(1, 8'h10, 64'h503);
      wait_log(b + 1, 30, "mid_rst_start");
      reset = 1'b1;
      tick();
      chk("mr_state",  64'(state),    64'd0);
      chk("mr_grant",  64'(grant_q),  64'd0);
      chk("mr_out_wr", 64'(out_wr),   64'd0);
      chk("mr_eop",    64'(eop),      64'd0);
      chk("mr_rd_en",  64'(in_rd_en), 64'd0);
      chk("mr_data",   out_data,      64'd0);
      chk("mr_ctrl",   64'(out_ctrl), 64'd0);
      chk("mr_fifo",   64'(tl[1] - hd[1]), 64'd3);
      chk("mr_count",  64'(log_n),    64'(b + 1));
      reset = 1'b0;
      wait_log(b + 4, 30, "mr_drain");
      for (int i = 1; i < 4; i++)
         chk_word("mr_w", b + i, (i == 3) ? 8'h10 : 8'h00, 64'h500 + 64'(i), i == 3);

      // Back-to-back packets from a single queue
      b = log_n;
      push_pkt3(2, 64'h600);
      push_pkt3(2, 64'h610);
      wait_log(b + 6, 40, "b2b_done");
      chk("b2b_gap",  64'(log_cyc[b + 3] - log_cyc[b + 2]), 64'd2);
      chk_word("b2b_end1",   b + 2, 8'h10, 64'h602, 1'b1);
      chk_word("b2b_start2", b + 3, 8'hFF, 64'h610, 1'b0);
      chk_word("b2b_end2",   b + 5, 8'h10, 64'h612, 1'b1);
      chk("b2b_grant", 64'(grant_q), 64'd2);

`ifdef INPUT_RR_ARBITER_STATS_EN
      // Packet counters
      reset = 1'b1;
      tick();
      reset = 1'b0;
      b = log_n;
      push_pkt3(1, 64'h700);
      push_pkt3(1, 64'h710);
      push_pkt3(1, 64'h720);
      wait_log(b + 9, 60, "st_done");
      repeat (2) tick();
      chk("st_q0", 64'(pkt_cnt[31:0]),   64'd0);
      chk("st_q1", 64'(pkt_cnt[63:32]),  64'd3);
      chk("st_q2", 64'(pkt_cnt[95:64]),  64'd0);
      chk("st_q3", 64'(pkt_cnt[127:96]), 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("st_clr", 64'(|pkt_cnt), 64'd0);
`endif

      tick();
      chk("latency_errs",  64'(lat_err),   64'd0);
      chk("protocol_errs", 64'(proto_err), 64'd0);
      chk("stray_eop",     64'(eop_err),   64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/input_rr_arbiter.md
INPUT_RR_ARBITER -- requirements
Module: input_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: packet data word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8: control word width.
REQ-003 SHALL have parameter NUM_QUEUES, default 4: number of input queues (2..8).
REQ-004 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, NUM_QUEUES*DATA_WIDTH: queue i head word at slice i (FWFT FIFOs).
REQ-007 SHALL have port in_ctrl, input, NUM_QUEUES*CTRL_WIDTH: queue i head ctrl at slice i.
REQ-008 SHALL have port in_empty, input, NUM_QUEUES: queue i has no word.
REQ-009 SHALL have port in_rd_en, output, NUM_QUEUES: pop queue i; at most one bit high.
REQ-010 SHALL have port out_data/out_ctrl, output, DATA_WIDTH/CTRL_WIDTH: registered output word.
REQ-011 SHALL have port out_wr, output, 1: out_data/out_ctrl valid this cycle.
REQ-012 SHALL have port out_rdy, input, 1: downstream accepts a word next cycle.
REQ-013 SHALL have port state, output, 1: 0 = IDLE, 1 = IN_PKT.
REQ-014 SHALL have port eop, output, 1: one-cycle pulse with the out_wr of a packet's last word.
REQ-015 SHALL have port grant_q, output, log2(NUM_QUEUES): currently or last granted queue.

Function
REQ-016 SHALL implement FSM IDLE -> IN_PKT -> IDLE.
REQ-017 In IDLE, SHALL pick the first non-empty queue searching upward, with wrap-around, from rr_ptr; load grant_q; go to IN_PKT next cycle; no pop in IDLE.
REQ-018 In IN_PKT, in_rd_en[grant_q] SHALL equal !in_empty[grant_q] && out_rdy.
REQ-019 A popped word SHALL appear on out_data/out_ctrl with out_wr=1 exactly one cycle after the pop (latency 1).
REQ-020 Packet end SHALL be the first popped word with in_ctrl != 0 that follows at least one popped word with in_ctrl == 0; leading nonzero-ctrl header words are not an end.
REQ-021 On the end-word pop, SHALL return to IDLE, set rr_ptr = (grant_q+1) mod NUM_QUEUES, and assert eop with that word's out_wr.
REQ-022 Granted queue empty mid-packet SHALL stall in IN_PKT with no pop, out_wr=0, and no regrant.
REQ-023 out_rdy low SHALL stall popping without losing or duplicating words.
REQ-024 All queues empty in IDLE SHALL keep IDLE with rr_ptr unchanged.
REQ-025 A single non-empty queue SHALL be regranted back-to-back, one IDLE cycle between packets.

Reset
REQ-026 On reset, SHALL clear state to IDLE, rr_ptr and grant_q to 0, out_wr, eop and in_rd_en to 0, out_data and out_ctrl to 0.
REQ-027 Reset mid-packet SHALL abandon the packet with no further out_wr; the remainder stays in its FIFO.

Configuration
REQ-028 With INPUT_RR_ARBITER_STATS_EN defined, SHALL add output pkt_cnt, NUM_QUEUES*32, per-queue packets-forwarded counters, incremented on eop, wrapping at 2^32, cleared on reset.
REQ-029 Without INPUT_RR_ARBITER_STATS_EN, SHALL have no pkt_cnt port and no counter logic; other behaviour identical.

Structure
REQ-030 SHALL place state encodings IDLE/IN_PKT and default widths in shared package in_arb_pkg.
REQ-031 SHALL implement the wrap-around first-non-empty search as sub-module rr_select (inputs req vector and ptr; outputs index and valid).

Verification
REQ-032 Q1 holds a 3-word packet (ctrl FF,00,10), all other queues empty -> out_wr words FF,00,10 in order; eop with the third; state returns to 0; rr_ptr=2.
REQ-033 All 4 queues hold one packet each, rr_ptr=0 -> grant order 0,1,2,3; four eop pulses; rr_ptr=0 after.
REQ-034 Q2 mid-packet, out_rdy low for 5 cycles -> no pop, no out_wr; stream resumes with nothing lost or duplicated.
REQ-035 Q0 runs empty after 2 of 4 words while Q3 non-empty -> hold grant 0, no switch; finish Q0 when refilled.
REQ-036 reset asserted during word 2 of a packet -> next cycle all outputs at reset values, state=0, grant_q=0.
REQ-037 With STATS_EN, 3 packets from Q1 -> pkt_cnt slice 1 = 3; others 0; cleared by reset.
